// File: rtl/l1i_refill_pkg.sv
// l1i_refill_pkg: shared types and helpers for the L1 instruction refill engine.
// Holds the FSM state type, beat width and the line-to-beat conversion.
package l1i_refill_pkg;

    localparam int BEAT_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COLLECT,
        STREAM,
        SETTLE
    } refill_state_t;

    function automatic int beats_per_line(input int b);
        return b / 8;
    endfunction

endpackage

// File: rtl/l1i_refill_ctrl_buffer.sv
// refill_line_buffer: one full cache line of 64-bit beats.
// Single write port; registered read port that reads back zero when idle.
module refill_line_buffer
    import l1i_refill_pkg::*;
#(
    parameter int BEATS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [$clog2(BEATS)-1:0]   widx,
    input  logic [BEAT_W-1:0]          wdata,
    input  logic                       re,
    input  logic [$clog2(BEATS)-1:0]   ridx,
    output logic [BEAT_W-1:0]          rdata
);

    logic [BEAT_W-1:0] mem [BEATS];

    // Line storage; contents are only meaningful once a full line is collected
    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
    end

    // Registered read; drops to zero outside streaming so the beat bus is quiet
    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[ridx];
        else         rdata <= '0;
    end

endmodule

// File: rtl/l1i_refill_ctrl.sv
// l1i_refill_ctrl: fetches a missing I-line, buffers it, streams it gaplessly.
// Optional counters enabled by defining L1I_REFILL_PERF_EN.
module l1i_refill_ctrl
    import l1i_refill_pkg::*;
#(
    parameter int B = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        L1IMiss,
    input  logic [31:0] Address,
    output logic        RepReady,
    output logic [63:0] RepWord,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic        MemRValid,
    input  logic [63:0] MemRData
`ifdef L1I_REFILL_PERF_EN
    ,
    output logic [31:0] RefillCount,
    output logic [31:0] StallCycles,
    output logic [31:0] DiscardCount
`endif
);

    localparam int BEATS = beats_per_line(B);
    localparam int OFF   = $clog2(B);
    localparam int IW    = $clog2(BEATS);
    localparam int CW    = IW + 1;

    localparam logic [2:0] StIdle    = IDLE;
    localparam logic [2:0] StReq     = REQ;
    localparam logic [2:0] StCollect = COLLECT;
    localparam logic [2:0] StStream  = STREAM;
    localparam logic [2:0] StSettle  = SETTLE;

    logic [2:0]    state;
    logic [CW-1:0] beatCnt;
    logic [CW-1:0] outCnt;
    logic          lastBeat;
    logic          sameBlock;
    logic          toStream;
    logic          toDiscard;
    logic          bufWe;
    logic          bufRe;
    logic [IW-1:0] bufRidx;
    logic          unusedAddrLow;

    assign unusedAddrLow = ^Address[OFF-1:0];

    assign lastBeat  = (state == StCollect) && MemRValid
                       && (beatCnt == CW'(BEATS - 1));
    assign sameBlock = Address[31:OFF] == MemAddr[31:OFF];
    assign toStream  = lastBeat && L1IMiss && sameBlock;
    assign toDiscard = lastBeat && !toStream;

    assign bufWe   = (state == StCollect) && MemRValid;
    assign bufRe   = toStream
                     || ((state == StStream) && (outCnt != CW'(BEATS)));
    assign bufRidx = toStream ? '0 : outCnt[IW-1:0];

    refill_line_buffer #(.BEATS(BEATS)) uBuf (
        .clk   (clk),
        .reset (reset),
        .we    (bufWe),
        .widx  (beatCnt[IW-1:0]),
        .wdata (MemRData),
        .re    (bufRe),
        .ridx  (bufRidx),
        .rdata (RepWord)
    );

    // Refill FSM: request, collect full line, stream it, settle one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            MemReq   <= 1'b0;
            MemAddr  <= '0;
            beatCnt  <= '0;
            outCnt   <= '0;
            RepReady <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (L1IMiss) begin
                        MemAddr <= {Address[31:OFF], {OFF{1'b0}}};
                        MemReq  <= 1'b1;
                        state   <= StReq;
                    end
                end
                StReq: begin
                    if (MemAck) begin
                        MemReq  <= 1'b0;
                        beatCnt <= '0;
                        state   <= StCollect;
                    end
                end
                StCollect: begin
                    if (MemRValid) begin
                        beatCnt <= beatCnt + CW'(1);
                        if (toStream) begin
                            outCnt   <= CW'(1);
                            RepReady <= 1'b1;
                            state    <= StStream;
                        end else if (toDiscard) begin
                            state <= StIdle;
                        end
                    end
                end
                StStream: begin
                    if (outCnt == CW'(BEATS)) begin
                        RepReady <= 1'b0;
                        state    <= StSettle;
                    end else begin
                        outCnt <= outCnt + CW'(1);
                    end
                end
                StSettle: state <= StIdle;
                default:  state <= StIdle;
            endcase
        end
    end

`ifdef L1I_REFILL_PERF_EN
    // Saturating event counters for refills, busy cycles and discarded lines
    always_ff @(posedge clk) begin
        if (reset) begin
            RefillCount  <= '0;
            StallCycles  <= '0;
            DiscardCount <= '0;
        end else begin
            if (toStream && (RefillCount != '1))
                RefillCount <= RefillCount + 32'd1;
            if ((state != StIdle) && (StallCycles != '1))
                StallCycles <= StallCycles + 32'd1;
            if (toDiscard && (DiscardCount != '1))
                DiscardCount <= DiscardCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l1i_refill_ctrl.sv
// tb_l1i_refill_ctrl: directed plus randomized refill scenarios.
// Expected lines, addresses and stream/discard outcomes come from a line-level model.
module tb_l1i_refill_ctrl;

    localparam int B     = 64;
    localparam int BEATS = B / 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        L1IMiss;
    logic [31:0] Address;
    logic        RepReady;
    logic [63:0] RepWord;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic        MemRValid;
    logic [63:0] MemRData;
`ifdef L1I_REFILL_PERF_EN
    logic [31:0] RefillCount;
    logic [31:0] StallCycles;
    logic [31:0] DiscardCount;
`endif

    int checks = 0;
    int errors = 0;
    int expRefills = 0;
    int expDiscards = 0;
    logic [63:0] line [BEATS];

    l1i_refill_ctrl #(.B(B)) dut (
        .clk          (clk),
        .reset        (reset),
        .L1IMiss      (L1IMiss),
        .Address      (Address),
        .RepReady     (RepReady),
        .RepWord      (RepWord),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemAck       (MemAck),
        .MemRValid    (MemRValid),
        .MemRData     (MemRData)
`ifdef L1I_REFILL_PERF_EN
        ,
        .RefillCount  (RefillCount),
        .StallCycles  (StallCycles),
        .DiscardCount (DiscardCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkPerf();
`ifdef L1I_REFILL_PERF_EN
        checkEq("refillCount", 64'(RefillCount), 64'(expRefills));
        checkEq("discardCount", 64'(DiscardCount), 64'(expDiscards));
`endif
    endtask

    // abortMode: 0 none, 1 drop miss mid-collect, 2 move to altAddr mid-collect
    task automatic doRefill(input logic [31:0] addr, input int ackDelay,
                            input int gapMode, input int abortMode,
                            input logic [31:0] altAddr, input int resetBeat);
        logic        seen;
        logic        missEnd;
        logic [31:0] addrEnd;
        logic        expStream;
        logic [31:0] expAddr;
        int          gaps;

        expAddr   = (addr / B) * B;
        missEnd   = (abortMode != 1);
        addrEnd   = (abortMode == 2) ? altAddr : addr;
        expStream = missEnd && ((addrEnd / B) == (addr / B));

        Address = addr;
        L1IMiss = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = MemReq;
        end
        checkEq("reqSeen", 64'(seen), 64'd1);
        if (!seen) return;
        checkEq("memAddr", 64'(MemAddr), 64'(expAddr));

        for (int i = 0; i < ackDelay; i++) begin
            tick();
            checkEq("reqHold", {31'd0, MemReq, MemAddr}, {31'd0, 1'b1, expAddr});
        end
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        checkEq("reqDrop", 64'(MemReq), 64'd0);

        for (int k = 0; k < BEATS; k++) begin
            if (gapMode == 1)      gaps = (k > 0) ? 1 : 0;
            else if (gapMode == 2) gaps = $urandom_range(0, 2);
            else                   gaps = 0;
            MemRValid = 1'b0;
            for (int g = 0; g < gaps; g++) begin
                tick();
                checkEq("collectQuiet", 64'(RepReady), 64'd0);
            end
            if (k == BEATS / 2) begin
                if (abortMode == 1) L1IMiss = 1'b0;
                if (abortMode == 2) Address = altAddr;
            end
            MemRValid = 1'b1;
            MemRData  = line[k];
            tick();
            if (k == BEATS - 1)
                checkEq("streamStart", 64'(RepReady), 64'(expStream));
            else
                checkEq("collectQuiet", 64'(RepReady), 64'd0);
        end
        MemRValid = 1'b0;
        MemRData  = '0;

        if (expStream) begin
            expRefills++;
            for (int k = 0; k < BEATS; k++) begin
                checkEq("repReady", 64'(RepReady), 64'd1);
                checkEq("repWord", RepWord, line[k]);
                if (k == resetBeat) begin
                    reset   = 1'b1;
                    L1IMiss = 1'b0;
                    tick();
                    reset = 1'b0;
                    checkEq("rstRepReady", 64'(RepReady), 64'd0);
                    checkEq("rstMemReq", 64'(MemReq), 64'd0);
                    checkEq("rstRepWord", RepWord, 64'd0);
                    expRefills  = 0;
                    expDiscards = 0;
                    checkPerf();
                    return;
                end
                tick();
            end
            checkEq("settleQuiet", 64'(RepReady), 64'd0);
            L1IMiss = 1'b0;
            tick();
            checkEq("idleQuiet", {62'd0, RepReady, MemReq}, 64'd0);
        end else begin
            expDiscards++;
            if (abortMode == 1) begin
                tick();
                checkEq("idleNoReq", 64'(MemReq), 64'd0);
            end
        end
        checkPerf();
    endtask

    task automatic fillRandom();
        for (int k = 0; k < BEATS; k++) line[k] = {$urandom, $urandom};
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] alt;
        int mode;

        reset     = 1'b1;
        L1IMiss   = 1'b0;
        Address   = '0;
        MemAck    = 1'b0;
        MemRValid = 1'b0;
        MemRData  = '0;

        for (int i = 0; i < 10; i++) begin
            tick();
            checkEq("rstOuts", {RepReady, MemReq, RepWord, MemAddr[30:0]}, 96'd0);
        end
`ifdef L1I_REFILL_PERF_EN
        checkEq("rstStall", 64'(StallCycles), 64'd0);
`endif
        checkPerf();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkEq("noReqIdle", 64'(MemReq), 64'd0);
        end

        for (int k = 0; k < BEATS; k++) line[k] = {32'(k * k), 32'(k)};
        doRefill(32'h0000_1234, 3, 0, 0, 32'h0, -1);
        doRefill(32'h0000_1234, 2, 1, 0, 32'h0, -1);

        fillRandom();
        doRefill(32'h0000_0040, 1, 0, 1, 32'h0, -1);

        fillRandom();
        doRefill(32'h0000_0044, 0, 0, 2, 32'h0000_0080, -1);
        fillRandom();
        doRefill(32'h0000_0080, 1, 2, 0, 32'h0, -1);

        fillRandom();
        doRefill(32'h0000_1234, 1, 0, 0, 32'h0, 3);
        fillRandom();
        doRefill(32'h0000_2008, 2, 2, 0, 32'h0, -1);

        for (int n = 0; n < 25; n++) begin
            fillRandom();
            a    = $urandom;
            mode = $urandom_range(0, 3);
            if (mode == 3) mode = 0;
            if (mode == 2) begin
                alt = $urandom;
                doRefill(a, $urandom_range(0, 4), $urandom_range(0, 2),
                         2, alt, -1);
                if ((alt / B) != (a / B)) begin
                    fillRandom();
                    doRefill(alt, $urandom_range(0, 4), 2, 0, 32'h0, -1);
                end
            end else begin
                doRefill(a, $urandom_range(0, 4), $urandom_range(0, 2),
                         mode, 32'h0, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
